// File: rtl/uart_param_if.sv
// Host-side signal bundle for uart_param: TX request/status, RX status/data.
// rxBreak exists only when UART_PARAM_BREAK_DETECT_EN is defined.
`timescale 1ns/1ps
interface uart_param_if #(
  parameter int DATA_BITS = 8
);
  logic                 txEn;
  logic                 txStart;
  logic [DATA_BITS-1:0] in;
  logic                 txBusy;
  logic                 txDone;
  logic                 tx;
  logic                 rxEn;
  logic                 rx;
  logic                 rxBusy;
  logic                 rxDone;
  logic                 rxErr;
  logic                 rxParityErr;
  logic [DATA_BITS-1:0] out;
`ifdef UART_PARAM_BREAK_DETECT_EN
  logic                 rxBreak;
`endif

  modport master (
    output txEn, txStart, in, rxEn, rx,
`ifdef UART_PARAM_BREAK_DETECT_EN
    input  rxBreak,
`endif
    input  txBusy, txDone, tx, rxBusy, rxDone, rxErr, rxParityErr, out
  );

  modport slave (
    input  txEn, txStart, in, rxEn, rx,
`ifdef UART_PARAM_BREAK_DETECT_EN
    output rxBreak,
`endif
    output txBusy, txDone, tx, rxBusy, rxDone, rxErr, rxParityErr, out
  );
endinterface

// File: rtl/uart_param.sv
// Parametrised full-duplex UART (5..9 data bits, none/odd/even parity, 1..2 stop bits).
// Define UART_PARAM_BREAK_DETECT_EN to add the rxBreak pulse on an all-zero frame.
`timescale 1ns/1ps
module uart_param #(
  parameter int CLOCK_RATE = 12000000,
  parameter int BAUD_RATE  = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic        clk,
  input  logic        reset,
  uart_param_if.slave bus
);
  localparam int   TX_DIV  = CLOCK_RATE / BAUD_RATE;
  localparam int   RX_DIV  = CLOCK_RATE / (16 * BAUD_RATE);
  localparam int   TXW     = $clog2(TX_DIV);
  localparam int   RXW     = $clog2(RX_DIV);
  localparam logic PAR_ODD = (PARITY == 1);
  localparam logic PAR_EN  = (PARITY != 0);

  generate
    if (RX_DIV < 2 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
        STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_cfg
      $error("uart_param: illegal parameter set");
    end
  endgenerate

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_HIGH} rx_state_t;

  tx_state_t            tx_state_q, tx_state_d;
  logic [TXW-1:0]       tx_cnt_q, tx_cnt_d;
  logic [3:0]           tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0] tx_data_q, tx_data_d;
  logic                 tx_par_q, tx_par_d;
  logic                 tx_q, tx_d;
  logic                 tx_done_q, tx_done_d;
  logic                 tx_bit_end;

  assign tx_bit_end = (tx_cnt_q == TXW'(TX_DIV - 1));

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_bit_end ? '0 : tx_cnt_q + 1'b1;
    tx_bit_d   = tx_bit_q;
    tx_data_d  = tx_data_q;
    tx_par_d   = tx_par_q;
    tx_done_d  = 1'b0;
    unique case (tx_state_q)
      TX_IDLE: begin
        tx_cnt_d = '0;
        if (bus.txStart) begin
          tx_state_d = TX_START;
          tx_data_d  = bus.in;
          tx_par_d   = (^bus.in) ^ PAR_ODD;
        end
      end
      TX_START: if (tx_bit_end) begin
        tx_state_d = TX_DATA;
        tx_bit_d   = '0;
      end
      TX_DATA: if (tx_bit_end) begin
        tx_data_d = tx_data_q >> 1;
        if (tx_bit_q == 4'(DATA_BITS - 1)) begin
          tx_bit_d   = '0;
          tx_state_d = PAR_EN ? TX_PARITY : TX_STOP;
        end else begin
          tx_bit_d = tx_bit_q + 1'b1;
        end
      end
      TX_PARITY: if (tx_bit_end) begin
        tx_state_d = TX_STOP;
        tx_bit_d   = '0;
      end
      TX_STOP: if (tx_bit_end) begin
        if (tx_bit_q == 4'(STOP_BITS - 1)) begin
          tx_state_d = TX_IDLE;
          tx_done_d  = 1'b1;
        end else begin
          tx_bit_d = tx_bit_q + 1'b1;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
    if (!bus.txEn) begin
      tx_state_d = TX_IDLE;
      tx_cnt_d   = '0;
      tx_done_d  = 1'b0;
    end
    // Line level is registered from the next state so tx changes with the state.
    unique case (tx_state_d)
      TX_START:  tx_d = 1'b0;
      TX_DATA:   tx_d = tx_data_d[0];
      TX_PARITY: tx_d = tx_par_d;
      default:   tx_d = 1'b1;
    endcase
  end

  logic                 rx_s1_q, rx_s2_q, rx_prev_q;
  rx_state_t            rx_state_q, rx_state_d;
  logic [RXW-1:0]       rx_div_q, rx_div_d;
  logic [3:0]           rx_tick_q, rx_tick_d;
  logic [3:0]           rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
  logic [DATA_BITS-1:0] out_q, out_d;
  logic                 rx_par_q, rx_par_d;
  logic                 rx_stop0_q, rx_stop0_d;
  logic                 rx_stop_bad_q, rx_stop_bad_d;
  logic                 rx_done_q, rx_done_d, rx_err_q, rx_err_d, rx_perr_q, rx_perr_d;
  logic                 rx_tick, rx_sample, rx_fall, stop_bad_now, stop0_now, parity_bad;
`ifdef UART_PARAM_BREAK_DETECT_EN
  logic                 rx_brk_q, rx_brk_d;
`endif

  assign rx_tick      = (rx_div_q == RXW'(RX_DIV - 1));
  assign rx_sample    = rx_tick && (rx_tick_q == 4'd15);
  assign rx_fall      = rx_prev_q && !rx_s2_q;
  assign stop_bad_now = rx_stop_bad_q | ~rx_s2_q;
  assign stop0_now    = (rx_bit_q == 4'd0) ? rx_s2_q : rx_stop0_q;
  assign parity_bad   = PAR_EN && (rx_par_q != ((^rx_shift_q) ^ PAR_ODD));

  always_comb begin
    rx_state_d    = rx_state_q;
    rx_div_d      = rx_tick ? '0 : rx_div_q + 1'b1;
    rx_tick_d     = rx_tick ? rx_tick_q + 1'b1 : rx_tick_q;
    rx_bit_d      = rx_bit_q;
    rx_shift_d    = rx_shift_q;
    rx_par_d      = rx_par_q;
    rx_stop0_d    = rx_stop0_q;
    rx_stop_bad_d = rx_stop_bad_q;
    out_d         = out_q;
    rx_done_d     = 1'b0;
    rx_err_d      = 1'b0;
    rx_perr_d     = 1'b0;
`ifdef UART_PARAM_BREAK_DETECT_EN
    rx_brk_d      = 1'b0;
`endif
    unique case (rx_state_q)
      RX_IDLE: begin
        rx_div_d  = '0;
        rx_tick_d = '0;
        if (rx_fall) rx_state_d = RX_START;
      end
      // Mid start bit: re-align counters so later samples land mid-bit.
      RX_START: if (rx_tick && rx_tick_q == 4'd7) begin
        rx_div_d   = '0;
        rx_tick_d  = '0;
        rx_bit_d   = '0;
        rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (rx_sample) begin
        rx_shift_d = {rx_s2_q, rx_shift_q[DATA_BITS-1:1]};
        if (rx_bit_q == 4'(DATA_BITS - 1)) begin
          rx_bit_d      = '0;
          rx_stop_bad_d = 1'b0;
          rx_state_d    = PAR_EN ? RX_PARITY : RX_STOP;
        end else begin
          rx_bit_d = rx_bit_q + 1'b1;
        end
      end
      RX_PARITY: if (rx_sample) begin
        rx_par_d      = rx_s2_q;
        rx_bit_d      = '0;
        rx_stop_bad_d = 1'b0;
        rx_state_d    = RX_STOP;
      end
      RX_STOP: if (rx_sample) begin
        rx_stop_bad_d = stop_bad_now;
        rx_stop0_d    = stop0_now;
        if (rx_bit_q == 4'(STOP_BITS - 1)) begin
          rx_state_d = RX_WAIT_HIGH;
          out_d      = rx_shift_q;
          if (stop_bad_now)    rx_err_d  = 1'b1;
          else if (parity_bad) rx_perr_d = 1'b1;
          else                 rx_done_d = 1'b1;
`ifdef UART_PARAM_BREAK_DETECT_EN
          rx_brk_d = ~(|rx_shift_q) & ~stop0_now & ~(PAR_EN & rx_par_q);
`endif
        end else begin
          rx_bit_d = rx_bit_q + 1'b1;
        end
      end
      RX_WAIT_HIGH: if (rx_s2_q) rx_state_d = RX_IDLE;
      default: rx_state_d = RX_IDLE;
    endcase
    if (!bus.rxEn) begin
      rx_state_d = RX_IDLE;
      out_d      = out_q;
      rx_done_d  = 1'b0;
      rx_err_d   = 1'b0;
      rx_perr_d  = 1'b0;
`ifdef UART_PARAM_BREAK_DETECT_EN
      rx_brk_d   = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state_q    <= TX_IDLE;
      tx_cnt_q      <= '0;
      tx_bit_q      <= '0;
      tx_data_q     <= '0;
      tx_par_q      <= 1'b0;
      tx_q          <= 1'b1;
      tx_done_q     <= 1'b0;
      rx_s1_q       <= 1'b1;
      rx_s2_q       <= 1'b1;
      rx_prev_q     <= 1'b1;
      rx_state_q    <= RX_IDLE;
      rx_div_q      <= '0;
      rx_tick_q     <= '0;
      rx_bit_q      <= '0;
      rx_shift_q    <= '0;
      out_q         <= '0;
      rx_par_q      <= 1'b0;
      rx_stop0_q    <= 1'b1;
      rx_stop_bad_q <= 1'b0;
      rx_done_q     <= 1'b0;
      rx_err_q      <= 1'b0;
      rx_perr_q     <= 1'b0;
`ifdef UART_PARAM_BREAK_DETECT_EN
      rx_brk_q      <= 1'b0;
`endif
    end else begin
      tx_state_q    <= tx_state_d;
      tx_cnt_q      <= tx_cnt_d;
      tx_bit_q      <= tx_bit_d;
      tx_data_q     <= tx_data_d;
      tx_par_q      <= tx_par_d;
      tx_q          <= tx_d;
      tx_done_q     <= tx_done_d;
      rx_s1_q       <= bus.rx;
      rx_s2_q       <= rx_s1_q;
      rx_prev_q     <= rx_s2_q;
      rx_state_q    <= rx_state_d;
      rx_div_q      <= rx_div_d;
      rx_tick_q     <= rx_tick_d;
      rx_bit_q      <= rx_bit_d;
      rx_shift_q    <= rx_shift_d;
      out_q         <= out_d;
      rx_par_q      <= rx_par_d;
      rx_stop0_q    <= rx_stop0_d;
      rx_stop_bad_q <= rx_stop_bad_d;
      rx_done_q     <= rx_done_d;
      rx_err_q      <= rx_err_d;
      rx_perr_q     <= rx_perr_d;
`ifdef UART_PARAM_BREAK_DETECT_EN
      rx_brk_q      <= rx_brk_d;
`endif
    end
  end

  assign bus.tx          = tx_q;
  assign bus.txBusy      = (tx_state_q != TX_IDLE);
  assign bus.txDone      = tx_done_q;
  assign bus.rxBusy      = (rx_state_q != RX_IDLE) && (rx_state_q != RX_WAIT_HIGH);
  assign bus.rxDone      = rx_done_q;
  assign bus.rxErr       = rx_err_q;
  assign bus.rxParityErr = rx_perr_q;
  assign bus.out         = out_q;
`ifdef UART_PARAM_BREAK_DETECT_EN
  assign bus.rxBreak     = rx_brk_q;
`endif
endmodule

// File: tb/tb_uart_param.sv
// Directed bench: dut0 is the default 8N1 12 MHz/9600 core, dut1 a fast 7E1 core.
`timescale 1ns/1ps
module tb_uart_param;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0, rst1, loop0, loop1, rx0_drv, rx1_drv;
  int   n_checks = 0;
  int   n_errors = 0;

  uart_param_if #(.DATA_BITS(8)) if0 ();
  uart_param_if #(.DATA_BITS(7)) if1 ();

  assign if0.rx = loop0 ? if0.tx : rx0_drv;
  assign if1.rx = loop1 ? if1.tx : rx1_drv;

  uart_param dut0 (.clk(clk), .reset(rst0), .bus(if0.slave));
  uart_param #(.CLOCK_RATE(6400), .BAUD_RATE(100), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1))
    dut1 (.clk(clk), .reset(rst1), .bus(if1.slave));

  logic [1:0] tx_w, busy_w, done_w;
  assign tx_w   = {if1.tx, if0.tx};
  assign busy_w = {if1.txBusy, if0.txBusy};
  assign done_w = {if1.txDone, if0.txDone};

  int done0_n = 0, err0_n = 0, perr0_n = 0, txd0_n = 0;
  int done1_n = 0, err1_n = 0, perr1_n = 0, txd1_n = 0, brk1_n = 0;
  logic [7:0] rx0_log[$];

  always @(negedge clk) begin
    if (if0.rxDone) begin
      done0_n++;
      rx0_log.push_back(if0.out);
    end
    if (if0.rxErr)       err0_n++;
    if (if0.rxParityErr) perr0_n++;
    if (if0.txDone)      txd0_n++;
    if (if1.rxDone)      done1_n++;
    if (if1.rxErr)       err1_n++;
    if (if1.rxParityErr) perr1_n++;
    if (if1.txDone)      txd1_n++;
`ifdef UART_PARAM_BREAK_DETECT_EN
    if (if1.rxBreak)     brk1_n++;
`endif
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  // Samples tx mid-bit for each frame bit; returns when txDone is seen or the budget runs out.
  task automatic tx_capture(input int sel, input int div, input int nbits, input bit hold,
                            input bit chg, input logic [8:0] new_in,
                            output logic [11:0] frame, output int busy_n,
                            output int done_k, output bit start_ok);
    frame    = '0;
    busy_n   = 0;
    done_k   = -1;
    start_ok = 1'b0;
    for (int k = 1; k <= div * (nbits + 2); k++) begin
      @(negedge clk);
      if (k == 1) begin
        start_ok = (tx_w[sel] == 1'b0) && busy_w[sel];
        if (!hold) begin
          if (sel == 0) if0.txStart = 1'b0;
          else          if1.txStart = 1'b0;
        end
      end
      if (chg && k == 3 * div) begin
        if (sel == 0) if0.in = new_in[7:0];
        else          if1.in = new_in[6:0];
      end
      if (busy_w[sel]) busy_n++;
      for (int b = 0; b < nbits; b++)
        if (k == div / 2 + div * b) frame[b] = tx_w[sel];
      if (done_w[sel]) begin
        done_k = k;
        break;
      end
    end
  endtask

  task automatic drive1(input logic [11:0] bits, input int nbits, input logic idle);
    for (int i = 0; i < nbits; i++) begin
      rx1_drv = bits[i];
      repeat (64) @(negedge clk);
    end
    rx1_drv = idle;
    repeat (20) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired before the bench completed");
    $fatal(1, "timeout");
  end

  initial begin
    logic [11:0] frame;
    int busy_n, done_k, s0, s1, s2, s3, s4;
    bit start_ok;
    rst0 = 1'b1; rst1 = 1'b1; loop0 = 1'b1; loop1 = 1'b0; rx0_drv = 1'b1; rx1_drv = 1'b1;
    if0.txEn = 1'b1; if0.txStart = 1'b0; if0.in = '0; if0.rxEn = 1'b1;
    if1.txEn = 1'b1; if1.txStart = 1'b0; if1.in = '0; if1.rxEn = 1'b1;
    repeat (5) @(negedge clk);
    check("rst tx", if0.tx, 1);
    check("rst out", if0.out, 0);
    check("rst busy/done", {if0.txBusy, if0.txDone, if0.rxBusy, if0.rxDone, if0.rxErr, if0.rxParityErr}, 0);
    rst0 = 1'b0; rst1 = 1'b0;
    repeat (5) @(negedge clk);

    // 8N1 loopback of 0x7A
    s0 = done0_n; s1 = err0_n + perr0_n; s2 = txd0_n;
    if0.in = 8'h7A; if0.txStart = 1'b1;
    tx_capture(0, 1250, 10, 1'b0, 1'b0, 9'h0, frame, busy_n, done_k, start_ok);
    check("lb start tx0 busy1", start_ok, 1);
    check("lb frame", frame, 12'h2F4);
    check("lb busy cycles", busy_n, 12500);
    check("lb txDone cycle", done_k, 12501);
    repeat (3) @(negedge clk);
    check("lb txDone pulses", txd0_n - s2, 1);
    check("lb rxDone pulses", done0_n - s0, 1);
    check("lb out", if0.out, 8'h7A);
    check("lb error pulses", err0_n + perr0_n - s1, 0);

    // back-to-back with in changed mid-frame
    s0 = done0_n; s2 = txd0_n;
    if0.in = 8'h7A; if0.txStart = 1'b1;
    tx_capture(0, 1250, 10, 1'b1, 1'b1, 9'h0B1, frame, busy_n, done_k, start_ok);
    check("b2b frame1", frame, 12'h2F4);
    tx_capture(0, 1250, 10, 1'b0, 1'b0, 9'h0, frame, busy_n, done_k, start_ok);
    check("b2b restart no gap", start_ok, 1);
    check("b2b frame2", frame, 12'h362);
    check("b2b frame2 done cycle", done_k, 12501);
    repeat (3) @(negedge clk);
    check("b2b txDone pulses", txd0_n - s2, 2);
    check("b2b rxDone pulses", done0_n - s0, 2);
    check("b2b rx first", rx0_log[s0], 8'h7A);
    check("b2b rx second", rx0_log[s0 + 1], 8'hB1);

    // TX abort during data bit 4
    loop0 = 1'b0; s2 = txd0_n;
    if0.in = 8'h00; if0.txStart = 1'b1;
    @(negedge clk);
    if0.txStart = 1'b0;
    repeat (1250 * 5 + 600 - 1) @(negedge clk);
    check("abort pre tx", if0.tx, 0);
    check("abort pre busy", if0.txBusy, 1);
    if0.txEn = 1'b0;
    @(negedge clk);
    check("abort tx", if0.tx, 1);
    check("abort busy", if0.txBusy, 0);
    repeat (2600) @(negedge clk);
    check("abort no txDone", txd0_n - s2, 0);
    if0.txEn = 1'b1;

    // reset in the middle of a received frame
    s0 = done0_n + err0_n + perr0_n;
    rx0_drv = 1'b0;
    repeat (3000) @(negedge clk);
    check("rxrst busy before", if0.rxBusy, 1);
    rst0 = 1'b1;
    @(negedge clk);
    check("rxrst busy", if0.rxBusy, 0);
    check("rxrst out", if0.out, 0);
    check("rxrst tx", if0.tx, 1);
    rst0 = 1'b0; rx0_drv = 1'b1;
    repeat (5) @(negedge clk);
    check("rxrst no pulses", done0_n + err0_n + perr0_n - s0, 0);

    // 7E1: flipped parity on 0x55
    s0 = done1_n; s1 = perr1_n; s3 = err1_n;
    drive1(12'h3AA, 10, 1'b1);
    check("par err pulses", perr1_n - s1, 1);
    check("par err no done", done1_n - s0, 0);
    check("par err no rxErr", err1_n - s3, 0);
    check("par err out", if1.out, 7'h55);

    // 7E1 loopback of 0x55: parity bit 0
    loop1 = 1'b1; s0 = done1_n; s1 = perr1_n;
    if1.in = 7'h55; if1.txStart = 1'b1;
    tx_capture(1, 64, 10, 1'b0, 1'b0, 9'h0, frame, busy_n, done_k, start_ok);
    check("7e1 frame", frame, 12'h2AA);
    check("7e1 busy cycles", busy_n, 640);
    check("7e1 txDone cycle", done_k, 641);
    repeat (3) @(negedge clk);
    check("7e1 rxDone", done1_n - s0, 1);
    check("7e1 no parity err", perr1_n - s1, 0);
    check("7e1 out", if1.out, 7'h55);
    loop1 = 1'b0;

    // framing error, line held low, then a good frame
    s0 = done1_n; s3 = err1_n; s4 = brk1_n;
    drive1(12'h126, 10, 1'b0);
    repeat (100) @(negedge clk);
    check("frm rxErr", err1_n - s3, 1);
    check("frm no done", done1_n - s0, 0);
    check("frm busy while low", if1.rxBusy, 0);
    check("frm no break", brk1_n - s4, 0);
    rx1_drv = 1'b1;
    repeat (10) @(negedge clk);
    drive1(12'h2D8, 10, 1'b1);
    check("frm next rxDone", done1_n - s0, 1);
    check("frm next out", if1.out, 7'h6C);

    // 4-cycle glitch
    s0 = done1_n + err1_n + perr1_n;
    rx1_drv = 1'b0;
    repeat (2) @(negedge clk);
    check("glitch busy at 2", if1.rxBusy, 0);
    @(negedge clk);
    check("glitch busy at 3", if1.rxBusy, 1);
    @(negedge clk);
    rx1_drv = 1'b1;
    repeat (60) @(negedge clk);
    check("glitch busy after", if1.rxBusy, 0);
    check("glitch no pulses", done1_n + err1_n + perr1_n - s0, 0);

    // break: line low for two frame times
    s0 = done1_n; s1 = perr1_n; s3 = err1_n; s4 = brk1_n;
    rx1_drv = 1'b0;
    repeat (1280) @(negedge clk);
    rx1_drv = 1'b1;
    repeat (100) @(negedge clk);
    check("brk rxErr", err1_n - s3, 1);
    check("brk no done/perr", done1_n + perr1_n - s0 - s1, 0);
`ifdef UART_PARAM_BREAK_DETECT_EN
    check("brk rxBreak", brk1_n - s4, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
